// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream requester bundle and UART TX side of the arbiter.
// The master side drives the requests and tx_ready_i. The slave side is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_last_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          tx_valid_o;
  logic [DATA_WIDTH-1:0]         tx_data_o;
  logic                          tx_ready_i;
  logic [NUM_REQ-1:0]            grant_o;
  logic                          burst_cut_o;
  logic                          busy_o;

  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_ready_i,
    input  req_ready_o, tx_valid_o, tx_data_o, grant_o, burst_cut_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
    output req_ready_o, tx_valid_o, tx_data_o, grant_o, burst_cut_o, busy_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core between NUM_REQ byte streams.
// A grant is locked to one requester until its packet ends or MAX_BURST bytes pass.
// Bytes go through a single output register that supports zero-bubble streaming.
//
// state | meaning
// IDLE  | no grant; pick the next valid requester from rr_ptr
// XFER  | granted requester streams bytes into the output register
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  uart_tx_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ST_IDLE, ST_XFER} state_t;

  state_t                r_state, w_state_nxt;
  logic [PTR_W-1:0]      r_rr_ptr, r_gnt_idx, w_sel_idx, w_ptr_nxt;
  logic                  w_sel_found;
  logic [NUM_REQ-1:0]    r_grant, w_ready;
  logic [7:0]            r_burst_cnt;
  logic                  r_tx_valid, r_burst_cut;
  logic [DATA_WIDTH-1:0] r_tx_data, w_gnt_data;
  logic                  w_gnt_valid, w_gnt_last, w_accept, w_xfer, w_limit, w_end;

  // Search upward from rr_ptr with wrap; iterating far-to-near lets the nearest hit win.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid_i[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = PTR_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign w_gnt_valid = bus.req_valid_i[r_gnt_idx];
  assign w_gnt_last  = bus.req_last_i[r_gnt_idx];
  assign w_gnt_data  = bus.req_data_i[r_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_accept    = !r_tx_valid || bus.tx_ready_i;
  assign w_xfer      = (r_state == ST_XFER) && w_gnt_valid && w_accept;
  assign w_limit     = (({1'b0, r_burst_cnt} + 9'd1) == 9'(MAX_BURST));
  assign w_end       = w_xfer && (w_gnt_last || w_limit);
  assign w_ptr_nxt   = (int'(r_gnt_idx) == NUM_REQ - 1) ? '0 : r_gnt_idx + 1'b1;

  // Only the granted requester sees ready, and only when the output register can take a byte.
  always_comb begin
    w_ready = '0;
    if (r_state == ST_XFER) w_ready[r_gnt_idx] = w_accept;
  end

  // Next-state decode: a grant ends only on a transferring cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_sel_found) w_state_nxt = ST_XFER;
      ST_XFER: if (w_end)       w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grant, round-robin pointer, burst counter and burst-cut pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant     <= '0;
      r_gnt_idx   <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_burst_cut <= 1'b0;
    end else begin
      r_burst_cut <= 1'b0;
      if (r_state == ST_IDLE && w_sel_found) begin
        r_grant     <= NUM_REQ'(1) << w_sel_idx;
        r_gnt_idx   <= w_sel_idx;
        r_burst_cnt <= '0;
      end else if (w_xfer) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
        if (w_end) begin
          r_grant     <= '0;
          r_rr_ptr    <= w_ptr_nxt;
          r_burst_cut <= w_limit && !w_gnt_last;
        end
      end
    end
  end

  // Output register: load on transfer (even while draining), otherwise clear once drained.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (w_xfer) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= w_gnt_data;
    end else if (bus.tx_ready_i) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.tx_valid_o  = r_tx_valid;
  assign bus.tx_data_o   = r_tx_data;
  assign bus.grant_o     = r_grant;
  assign bus.burst_cut_o = r_burst_cut;
  assign bus.busy_o      = (r_state == ST_XFER) || r_tx_valid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=16).
// Requester byte queues feed a driver process. Expected TX bytes are queued in sb and
// checked at every TX handshake.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] sb [$];
  logic [8:0] src_q [4][$];
  logic [3:0] fire;
  int         cut_cnt = 0;
  int         cut_grant_bad = 0;
  logic [7:0] last_pop = 8'h00;
  logic [7:0] cut_byte = 8'h00;

  // Requester side transfers are sampled mid-cycle, when inputs are stable.
  always @(negedge clk) fire = bus.req_valid_i & bus.req_ready_o;

  // Driver: retire accepted bytes and present each queue head.
  always @(posedge clk) begin
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    #2;
    v = '0; l = '0; d = '0;
    for (int k = 0; k < 4; k++) begin
      if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      if (src_q[k].size() > 0) begin
        v[k]       = 1'b1;
        l[k]       = src_q[k][0][8];
        d[k*8 +: 8] = src_q[k][0][7:0];
      end
    end
    bus.req_valid_i = v;
    bus.req_last_i  = l;
    bus.req_data_i  = d;
  end

  // TX-side scoreboard and burst-cut monitor.
  always @(negedge clk) begin
    if (!rst && bus.tx_valid_o && bus.tx_ready_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected: got byte %02h, want no byte", bus.tx_data_o);
      end else begin
        last_pop = sb.pop_front();
        if (bus.tx_data_o !== last_pop) begin
          bad++;
          $display("FAIL tx_data: got %02h, want %02h", bus.tx_data_o, last_pop);
        end
      end
    end
    if (!rst && bus.burst_cut_o) begin
      cut_cnt++;
      cut_byte = last_pop;
      if (bus.grant_o !== 4'b0000) cut_grant_bad++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  function automatic bit pending();
    bit p;
    p = (sb.size() != 0) || bus.busy_o;
    for (int k = 0; k < 4; k++) if (src_q[k].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input int max_cyc, output bit ok);
    int n;
    n = 0;
    while (pending() && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    ok = !pending();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1;
    bus.tx_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      src_q[k].push_back({1'b0, 8'(8'h40 + 2*k)});
      src_q[k].push_back({1'b1, 8'(8'h41 + 2*k)});
    end
    for (int k = 0; k < 8; k++) sb.push_back(8'(8'h40 + k));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({bus.tx_valid_o, bus.tx_data_o, bus.grant_o, bus.req_ready_o, bus.burst_cut_o, bus.busy_o} !== 19'd0
          || bus.req_valid_i !== 4'b1111) begin
        bad++;
        $display("FAIL reset_outputs: got valid=%b data=%02h grant=%b ready=%b cut=%b busy=%b reqv=%b, want all 0 with reqv=1111",
                 bus.tx_valid_o, bus.tx_data_o, bus.grant_o, bus.req_ready_o, bus.burst_cut_o, bus.busy_o, bus.req_valid_i);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.grant_o !== 4'b0000) begin
      bad++; $display("FAIL reset_release_grant: got %b, want 0000", bus.grant_o);
    end
    @(negedge clk);
    total++;
    if (bus.grant_o !== 4'b0001) begin
      bad++; $display("FAIL first_grant: got %b, want 0001", bus.grant_o);
    end
    @(negedge clk);
    total++;
    if (bus.grant_o !== 4'b0001 || bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'h40) begin
      bad++;
      $display("FAIL first_byte_latency: got grant=%b valid=%b data=%02h, want 0001 1 40",
               bus.grant_o, bus.tx_valid_o, bus.tx_data_o);
    end
    wait_drain(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL reset_drain: got pending, want drained"); end
  endtask

  task automatic test_two_req();
    logic [3:0] glog [$];
    int i, a, z, b, n;
    bit ok;
    @(posedge clk); #1;
    src_q[0].push_back({1'b0, 8'h10}); src_q[0].push_back({1'b0, 8'h11}); src_q[0].push_back({1'b1, 8'h12});
    src_q[2].push_back({1'b0, 8'h20}); src_q[2].push_back({1'b0, 8'h21}); src_q[2].push_back({1'b1, 8'h22});
    sb.push_back(8'h10); sb.push_back(8'h11); sb.push_back(8'h12);
    sb.push_back(8'h20); sb.push_back(8'h21); sb.push_back(8'h22);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      glog.push_back(bus.grant_o);
    end
    n = glog.size();
    i = 0; a = 0; z = 0; b = 0;
    while (i < n && glog[i] == 4'b0000) i++;
    while (i < n && glog[i] == 4'b0001) begin a++; i++; end
    while (i < n && glog[i] == 4'b0000) begin z++; i++; end
    while (i < n && glog[i] == 4'b0100) begin b++; i++; end
    total++;
    if (a != 3 || z != 1 || b != 3) begin
      bad++;
      $display("FAIL two_req_grants: got 0001 x%0d, 0000 x%0d, 0100 x%0d, want 3,1,3", a, z, b);
    end
    wait_drain(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL two_req_drain: got pending, want drained"); end
  endtask

  task automatic test_fairness();
    logic [3:0] gq [$];
    logic [3:0] prev;
    logic [3:0] exp_order [6];
    bit ok;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    apply_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) begin
        src_q[k].push_back({1'b1, 8'(8'h50 + 4*r + k)});
        sb.push_back(8'(8'h50 + 4*r + k));
      end
    prev = 4'b0000;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.grant_o != 4'b0000 && prev == 4'b0000) gq.push_back(bus.grant_o);
      prev = bus.grant_o;
    end
    total++;
    if (gq.size() != 8) begin
      bad++; $display("FAIL fair_grant_count: got %0d, want 8", gq.size());
    end
    for (int j = 0; j < 6 && j < gq.size(); j++) begin
      total++;
      if (gq[j] !== exp_order[j]) begin
        bad++; $display("FAIL fair_order[%0d]: got %b, want %b", j, gq[j], exp_order[j]);
      end
    end
    wait_drain(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL fair_drain: got pending, want drained"); end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    int n;
    bit ok;
    bus.tx_ready_i = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      src_q[0].push_back({(k == 5), 8'(8'h30 + k)});
      sb.push_back(8'(8'h30 + k));
    end
    n = 0;
    while (sb.size() > 4 && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (sb.size() != 4) begin
      bad++; $display("FAIL bp_start: got %0d bytes pending, want 4", sb.size());
    end
    bus.tx_ready_i = 1'b0;
    held = sb[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== held || bus.req_ready_o[0] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%02h ready0=%b, want 1 %02h 0",
                 c, bus.tx_valid_o, bus.tx_data_o, bus.req_ready_o[0], held);
      end
    end
    @(posedge clk); #1;
    bus.tx_ready_i = 1'b1;
    wait_drain(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_drain: got pending, want drained"); end
  endtask

  task automatic test_burst();
    bit ok;
    @(posedge clk); #1;
    cut_cnt = 0; cut_grant_bad = 0;
    for (int k = 0; k < 20; k++) src_q[1].push_back({(k == 19), 8'(k)});
    src_q[3].push_back({1'b1, 8'hA5});
    for (int k = 0; k < 16; k++) sb.push_back(8'(k));
    sb.push_back(8'hA5);
    for (int k = 16; k < 20; k++) sb.push_back(8'(k));
    wait_drain(300, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL burst_drain: got pending, want drained"); end
    total++;
    if (cut_cnt != 1 || cut_grant_bad != 0 || cut_byte !== 8'h0F) begin
      bad++;
      $display("FAIL burst_cut: got pulses=%0d with_grant=%0d after=%02h, want 1 0 0f",
               cut_cnt, cut_grant_bad, cut_byte);
    end
    @(posedge clk); #1;
    cut_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      src_q[2].push_back({(k == 15), 8'(8'h80 + k)});
      sb.push_back(8'(8'h80 + k));
    end
    wait_drain(300, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL burst_last_drain: got pending, want drained"); end
    total++;
    if (cut_cnt != 0) begin
      bad++; $display("FAIL burst_last_precedence: got %0d pulses, want 0", cut_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] first_g;
    int n;
    bit ok;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) src_q[2].push_back({(k == 4), 8'(8'h60 + k)});
    sb.push_back(8'h60); sb.push_back(8'h61);
    n = 0;
    while (sb.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    for (int k = 0; k < 4; k++) src_q[k].delete();
    #1;
    total++;
    if (bus.tx_valid_o !== 1'b0 || bus.grant_o !== 4'b0000 || bus.busy_o !== 1'b0 || bus.req_ready_o !== 4'b0000) begin
      bad++;
      $display("FAIL midreset_async: got valid=%b grant=%b busy=%b ready=%b, want 0 0000 0 0000",
               bus.tx_valid_o, bus.grant_o, bus.busy_o, bus.req_ready_o);
    end
    @(posedge clk); #1;
    src_q[0].push_back({1'b1, 8'h70});
    src_q[3].push_back({1'b1, 8'h73});
    sb.push_back(8'h70); sb.push_back(8'h73);
    @(posedge clk); #1;
    rst = 1'b0;
    first_g = 4'b0000;
    n = 0;
    while (first_g == 4'b0000 && n < 10) begin
      @(negedge clk);
      first_g = bus.grant_o;
      n++;
    end
    total++;
    if (first_g !== 4'b0001) begin
      bad++; $display("FAIL midreset_restart: got grant %b, want 0001", first_g);
    end
    wait_drain(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midreset_drain: got pending, want drained"); end
  endtask

  initial begin
    test_reset();
    test_two_req();
    test_fairness();
    test_backpressure();
    test_burst();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
